// File: rtl/pdm_dac_multi.sv
// Multi-channel PDM DAC: double-buffered PCM frames feed per-channel sigma-delta modulators.
// Define PDM_DAC_SECOND_ORDER_EN for second-order loops; the default build is first-order carry modulation.
module pdm_dac_multi #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int DIV_WIDTH    = 8,
    parameter int OSR_WIDTH    = 10
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               enable,
    input  logic [DIV_WIDTH-1:0]               clk_div,
    input  logic [OSR_WIDTH-1:0]               osr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_data,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    output logic                               underrun,
    output logic [15:0]                        underrun_count,
    output logic [NUM_CHANNELS-1:0]            pdm_out,
    output logic                               pdm_oe,
    output logic [1:0]                         state
);

    // state    | meaning
    // IDLE  0  | disabled, modulators cleared, outputs not driven
    // PRIME 1  | enabled, waiting for the first frame
    // RUN   2  | modulating, frames swapped in at frame boundaries
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam int FW = NUM_CHANNELS * DATA_WIDTH;

    logic [1:0]              state_q, state_d;
    logic [DIV_WIDTH-1:0]    div_q, div_d;
    logic [OSR_WIDTH-1:0]    frm_q, frm_d;
    logic [FW-1:0]           shadow_q, shadow_d;
    logic                    shadow_full_q, shadow_full_d;
    logic [FW-1:0]           active_q, active_d;
    logic [NUM_CHANNELS-1:0] pdm_q, pdm_d;
    logic                    underrun_q, underrun_d;
    logic [15:0]             urun_cnt_q, urun_cnt_d;

    logic tick;
    logic boundary;
    logic xfer;

    assign tick     = (state_q == ST_RUN) && (div_q == clk_div);
    assign boundary = tick && (frm_q == osr);
    assign xfer     = sample_valid && !shadow_full_q;

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        frm_d         = frm_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        active_d      = active_q;
        underrun_d    = 1'b0;
        urun_cnt_d    = urun_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (shadow_full_q) begin
                    active_d      = shadow_q;
                    shadow_full_d = 1'b0;
                    div_d         = '0;
                    frm_d         = '0;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    frm_d = boundary ? '0 : frm_q + 1'b1;
                end
                if (boundary) begin
                    if (shadow_full_q) begin
                        active_d      = shadow_q;
                        shadow_full_d = 1'b0;
                    end else begin
                        underrun_d = 1'b1;
                        if (urun_cnt_q != 16'hFFFF) begin
                            urun_cnt_d = urun_cnt_q + 16'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An incoming frame always owns the shadow write, even on a boundary swap.
        if (xfer) begin
            shadow_d      = sample_data;
            shadow_full_d = 1'b1;
        end

        if (!enable) begin
            state_d       = ST_IDLE;
            div_d         = '0;
            frm_d         = '0;
            shadow_full_d = 1'b0;
            underrun_d    = 1'b0;
        end
    end

`ifdef PDM_DAC_SECOND_ORDER_EN
    localparam int AW = DATA_WIDTH + 4;

    logic [NUM_CHANNELS*AW-1:0] a1_q, a1_d;
    logic [NUM_CHANNELS*AW-1:0] a2_q, a2_d;

    always_comb begin
        logic signed [AW-1:0] act;
        logic signed [AW-1:0] fb;
        logic signed [AW-1:0] a1_n;
        logic signed [AW-1:0] a2_n;
        a1_d  = a1_q;
        a2_d  = a2_q;
        pdm_d = pdm_q;
        act   = '0;
        fb    = '0;
        a1_n  = '0;
        a2_n  = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            act  = signed'({4'b0000, active_q[k*DATA_WIDTH +: DATA_WIDTH]});
            fb   = pdm_q[k] ? (AW'(1) << DATA_WIDTH) : '0;
            a1_n = signed'(a1_q[k*AW +: AW]) + act - fb;
            a2_n = signed'(a2_q[k*AW +: AW]) + a1_n - fb;
            if (tick) begin
                a1_d[k*AW +: AW] = a1_n;
                a2_d[k*AW +: AW] = a2_n;
                pdm_d[k]         = ~a2_n[AW-1];
            end
        end
        if (!enable) begin
            a1_d  = '0;
            a2_d  = '0;
            pdm_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            a1_q <= '0;
            a2_q <= '0;
        end else begin
            a1_q <= a1_d;
            a2_q <= a2_d;
        end
    end
`else
    logic [FW-1:0] acc_q, acc_d;

    // The carry out of acc + sample is the PDM bit; its long-run density is sample / 2^DATA_WIDTH.
    always_comb begin
        logic [DATA_WIDTH:0] sum;
        acc_d = acc_q;
        pdm_d = pdm_q;
        sum   = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            sum = {1'b0, acc_q[k*DATA_WIDTH +: DATA_WIDTH]}
                + {1'b0, active_q[k*DATA_WIDTH +: DATA_WIDTH]};
            if (tick) begin
                acc_d[k*DATA_WIDTH +: DATA_WIDTH] = sum[DATA_WIDTH-1:0];
                pdm_d[k]                          = sum[DATA_WIDTH];
            end
        end
        if (!enable) begin
            acc_d = '0;
            pdm_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            frm_q         <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            active_q      <= '0;
            pdm_q         <= '0;
            underrun_q    <= 1'b0;
            urun_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            frm_q         <= frm_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            active_q      <= active_d;
            pdm_q         <= pdm_d;
            underrun_q    <= underrun_d;
            urun_cnt_q    <= urun_cnt_d;
        end
    end

    assign sample_ready   = ~shadow_full_q;
    assign underrun       = underrun_q;
    assign underrun_count = urun_cnt_q;
    assign pdm_out        = pdm_q;
    assign pdm_oe         = (state_q == ST_RUN);
    assign state          = state_q;

endmodule

// File: tb/tb_pdm_dac_multi.sv
// Directed bench for pdm_dac_multi (default first-order build, 16-bit samples, 2 channels).
module tb_pdm_dac_multi;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [7:0]  clk_div;
    logic [9:0]  osr;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        underrun;
    logic [15:0] underrun_count;
    logic [1:0]  pdm_out;
    logic        pdm_oe;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    pdm_dac_multi dut (
        .clk            (clk),
        .resetn         (resetn),
        .enable         (enable),
        .clk_div        (clk_div),
        .osr            (osr),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .pdm_out        (pdm_out),
        .pdm_oe         (pdm_oe),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Offer a frame at a negedge and return at the negedge after the accepting edge.
    task automatic send_frame(input logic [15:0] c0, input logic [15:0] c1);
        bit got = 1'b0;
        sample_data  = {c1, c0};
        sample_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sample_ready) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) chk("frame_timeout", 0, 1);
        step();
        sample_valid = 1'b0;
    endtask

    // Restart from IDLE; returns at the negedge after PRIME->RUN with cyc = 0.
    task automatic start_run(input logic [15:0] c0, input logic [15:0] c1,
                             input logic [7:0] dv, input logic [9:0] ov);
        enable = 1'b0;
        step();
        enable  = 1'b1;
        clk_div = dv;
        osr     = ov;
        step();
        chk("prime_state", state, 1);
        send_frame(c0, c1);
        chk("prime_hold", state, 1);
        step();
        chk("run_state", state, 2);
        chk("run_oe", pdm_oe, 1);
        cyc = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones0, ones1, nchg, last, nu;
        logic prev;
        logic [15:0] base;

        resetn       = 1'b1;
        enable       = 1'b0;
        clk_div      = '0;
        osr          = '0;
        sample_data  = '0;
        sample_valid = 1'b0;
        step();
        step();
        resetn = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_ready", sample_ready, 1);
        chk("rst_oe", pdm_oe, 0);
        chk("rst_pdm", pdm_out, 0);
        chk("rst_urun", underrun, 0);
        chk("rst_count", underrun_count, 0);

        // Quarter / three-quarter scale over a full 2^16-tick period, frames withheld.
        start_run(16'h4000, 16'hC000, 8'd0, 10'd15);
        chk("run_ready", sample_ready, 1);
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 65536; i++) begin
            step();
            ones0 += int'(pdm_out[0]);
            ones1 += int'(pdm_out[1]);
        end
        chk("dens_4000", ones0, 16384);
        chk("dens_c000", ones1, 49152);
        chk("urun_4096", underrun_count, 4096);
        chk("oe_run", pdm_oe, 1);

        // Extremes.
        start_run(16'h0000, 16'hFFFF, 8'd0, 10'd15);
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            ones0 += int'(pdm_out[0]);
            ones1 += int'(pdm_out[1]);
        end
        chk("dens_0000", ones0, 0);
        chk("dens_ffff", ones1, 255);

        // Divide by 4: half scale toggles on every tick, first change on the second tick.
        start_run(16'h8000, 16'h4000, 8'd3, 10'd15);
        prev = pdm_out[0];
        nchg = 0;
        last = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (pdm_out[0] != prev) begin
                nchg++;
                chk("div_phase", cyc % 4, 0);
                if (nchg == 1) chk("div_first", cyc, 8);
                else chk("div_spacing", cyc - last, 4);
                last = cyc;
                prev = pdm_out[0];
            end
        end
        chk("div_changes", nchg, 15);

        // Underruns every 8 ticks with the active value held.
        start_run(16'h2000, 16'h6000, 8'd0, 10'd7);
        base  = underrun_count;
        nu    = 0;
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (underrun) begin
                nu++;
                chk("urun_phase", cyc % 8, 0);
            end
            ones0 += int'(pdm_out[0]);
            ones1 += int'(pdm_out[1]);
        end
        chk("urun_pulses", nu, 8);
        chk("urun_delta", underrun_count, base + 16'd8);
        chk("hold_2000", ones0, 8);
        chk("hold_6000", ones1, 24);

        // Frame arriving on the boundary edge at index 72 counts as underrun and goes live at 80.
        while (cyc < 71) step();
        sample_data  = {16'h6000, 16'h0000};
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("coinc_urun", underrun, 1);
        chk("coinc_ready", sample_ready, 0);
        chk("coinc_count", underrun_count, base + 16'd9);
        ones0 = 0;
        while (cyc < 80) begin
            step();
            ones0 += int'(pdm_out[0]);
        end
        chk("coinc_old_active", ones0, 1);
        chk("coinc_no_urun", underrun, 0);
        chk("coinc_swap_ready", sample_ready, 1);
        ones0 = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            ones0 += int'(pdm_out[0]);
        end
        chk("coinc_new_active", ones0, 0);

        // Drop enable with the shadow full.
        send_frame(16'h1111, 16'h2222);
        chk("dis_shadow_full", sample_ready, 0);
        base   = underrun_count;
        enable = 1'b0;
        step();
        chk("dis_state", state, 0);
        chk("dis_oe", pdm_oe, 0);
        chk("dis_pdm", pdm_out, 0);
        chk("dis_ready", sample_ready, 1);
        chk("dis_count", underrun_count, base);

        // Reset in the middle of RUN.
        start_run(16'h1234, 16'h8000, 8'd0, 10'd3);
        base = underrun_count;
        for (int i = 0; i < 40; i++) step();
        chk("pre_rst_count", underrun_count, base + 16'd10);
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        chk("mrst_state", state, 0);
        chk("mrst_count", underrun_count, 0);
        chk("mrst_ready", sample_ready, 1);
        chk("mrst_oe", pdm_oe, 0);
        chk("mrst_pdm", pdm_out, 0);
        chk("mrst_urun", underrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pdm_dac_multi.md
Name: pdm_dac_multi

Overview:
- Multi-channel first-order sigma-delta (PDM) DAC, successor to the single-channel audio DAC in the wishbone DAC path.
- Accepts whole frames of unsigned PCM samples over a valid/ready handshake and double-buffers them.
- Modulates every channel at a programmable tick rate and drives one PDM bit per channel, tri-stated while disabled.
- Instantiated behind the wishbone DAC register block.

Parameters:
- DATA_WIDTH, 16, sample width per channel (unsigned).
- NUM_CHANNELS, 2, number of independent modulators.
- DIV_WIDTH, 8, width of the modulator tick divider.
- OSR_WIDTH, 10, width of the oversampling (ticks per frame) counter.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset; one clock; reset is synchronous and active-high
- enable  input  1  run request; low = modulators cleared, outputs tri-stated
- clk_div  input  DIV_WIDTH  modulator tick every clk_div+1 clocks
- osr  input  OSR_WIDTH  frame length in ticks, minus 1
- sample_data  input  NUM_CHANNELS*DATA_WIDTH  frame; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- sample_valid  input  1  frame offered
- sample_ready  output  1  shadow buffer empty
- underrun  output  1  one-clock pulse when a frame boundary finds the shadow empty while in RUN
- underrun_count  output  16  saturating underrun count, cleared by reset only
- pdm_out  output  NUM_CHANNELS  modulator bits (registered)
- pdm_oe  output  1  output enable for the pad tri-state; low drives pdm_out as z at the top level
- state  output  2  FSM state (IDLE=0, PRIME=1, RUN=2)

Behaviour:
Reset values:
- state=IDLE; all accumulators 0; shadow empty; active samples 0; counters 0.
- pdm_out=0, pdm_oe=0, sample_ready=1, underrun=0, underrun_count=0.

Handshake:
- Transfer occurs when sample_valid & sample_ready on a rising clk edge; the frame latches into shadow and shadow becomes full.
- sample_ready = shadow empty (registered); deasserts the cycle after a transfer.
- sample_valid is ignored while sample_ready=0.
- The source must hold sample_data stable while valid and not ready.

Tick:
- Divider counts 0..clk_div; tick asserts for one clk when it equals clk_div, then wraps to 0.
- clk_div=0 gives a tick every clock.
- Divider runs only in RUN and is held at 0 otherwise.

Frame counter:
- Counts ticks 0..osr; a frame boundary is the tick on which it equals osr; it then wraps to 0.

FSM:
- IDLE: pdm_oe=0, accumulators held at 0. Go to PRIME when enable=1.
- PRIME: pdm_oe=0, waits for shadow full. When full, copy shadow to active, empty shadow, and go to RUN. Divider and frame counter start from 0.
- RUN: pdm_oe=1. On each tick, for each channel k: {carry, acc_k} <= acc_k + active_k (DATA_WIDTH+1-bit sum), then pdm_out[k] <= carry. Long-run ones-density = active_k / 2^DATA_WIDTH exactly over any 2^DATA_WIDTH ticks. Between ticks pdm_out holds.
- Frame boundary in RUN, shadow full: active <= shadow; shadow empties; the new value is used from the next tick.
- Frame boundary in RUN, shadow empty: active holds, underrun pulses, underrun_count increments and saturates at 0xFFFF.
- Boundary coinciding with an incoming transfer: the transfer wins the shadow write. Active gets the old shadow content if it was full; otherwise it counts as an underrun and the new frame waits for the next boundary.
- enable=0 in any state: next clock goes to IDLE, clears accumulators, pdm_out, divider and frame counter, empties shadow, and drops pdm_oe. underrun_count is kept.
- resetn has priority over everything.
- clk_div and osr are sampled live; changing them mid-run takes effect at the next wrap.

Optional Feature:
- Macro: PDM_DAC_SECOND_ORDER_EN.
- Defined: each channel uses a second-order loop with signed DATA_WIDTH+4-bit a1, a2 and fb = pdm_out[k] ? 2^DATA_WIDTH : 0. Per tick: a1 <= a1 + active_k - fb; a2 <= a2 + a1_next - fb; pdm_out[k] <= (a2_next >= 0). All cleared like the first-order accumulators. Density matches first-order within ±1 count per 2^DATA_WIDTH ticks for inputs in [2^(DATA_WIDTH-4), 2^DATA_WIDTH - 2^(DATA_WIDTH-4)].
- Undefined: first-order carry modulator only; no extra registers.

Test Plan:
- Reset, then enable=1, clk_div=0, osr=15, single frame ch0=0x4000, ch1=0xC000 -> PRIME to RUN one clock after the frame is accepted; over 65536 ticks ch0 has 16384 ones and ch1 has 49152; pdm_oe=1.
- Frames 0x0000 and 0xFFFF -> ch0 constant 0; ch1 has 65535 ones per 65536 ticks.
- clk_div=3 -> pdm_out changes only on every 4th clk; tick spacing exactly 4 clocks.
- Withhold frames after the first, osr=7 -> underrun pulses every 8 ticks, count increments, active value is held, output density unchanged.
- Frame offered on the same clock as a boundary with shadow empty -> underrun=1; new frame goes active at the following boundary.
- Deassert enable mid-RUN -> next clock: pdm_oe=0, pdm_out=0, state=IDLE, sample_ready=1, underrun_count retained. Assert resetn during RUN -> all reset values, including count=0.
